// File: rtl/gray_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : gray_count_arbiter
// Purpose  : Shares one Gray-code step counter among N_REQ requesters.
//            Each granted request advances the count by one step. The
//            arbitration is round-robin, or fixed priority when
//            GRAY_ARB_FIXED_PRIO_EN is defined.
// Revision : 1.0
// ============================================================================
module gray_count_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 3
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [N_REQ-1:0] Req,
   input  logic             Clr,
   output logic [N_REQ-1:0] Grant,
   output logic             Ack,
   output logic [WIDTH-1:0] GrayOut,
   output logic             Overflow,
   output logic             Busy
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] bin_inc;
   logic             any_req;
   logic [IDX_W-1:0] win_idx;
   logic [N_REQ-1:0] win_onehot;

   assign any_req    = |Req;
   assign bin_inc    = bin + WIDTH'(1);
   assign win_onehot = N_REQ'(1) << win_idx;
   assign Busy       = (state != IDLE);

`ifdef GRAY_ARB_FIXED_PRIO_EN
   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      win_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (Req[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr;

   // Search begins just after the last winner, so it ends up lowest priority.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] cand;
      logic             found;
      win_idx = '0;
      idx     = 0;
      cand    = '0;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx  = (int'(rr_ptr) + 1 + i) % N_REQ;
         cand = IDX_W'(idx);
         if (!found && Req[cand]) begin
            win_idx = cand;
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         rr_ptr <= IDX_W'(N_REQ - 1);
      end else if (!Clr && state == IDLE && any_req) begin
         rr_ptr <= win_idx;
      end
   end
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_req) state_next = GRANT;
         GRANT:   state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (Clr) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset || Clr) begin
         bin      <= '0;
         GrayOut  <= '0;
         Overflow <= 1'b0;
         Grant    <= '0;
         Ack      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  Grant <= win_onehot;
               end
            end
            // The step commits here regardless of the winner's Req level.
            GRANT: begin
               bin     <= bin_inc;
               GrayOut <= bin_inc ^ (bin_inc >> 1);
               Ack     <= 1'b1;
               if (&bin) begin
                  Overflow <= 1'b1;
               end
            end
            ACK: begin
               Grant <= '0;
               Ack   <= 1'b0;
            end
            default: begin
               Grant <= '0;
               Ack   <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gray_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_count_arbiter
// Purpose  : Self-checking bench for gray_count_arbiter: vector table, hand
//            sequences and randomized traffic against a reference model.
// Revision : 1.0
// ============================================================================
module tb_gray_count_arbiter;

   localparam int N_REQ = 4;
   localparam int WIDTH = 3;

   logic             Clk = 1'b0;
   logic             Reset;
   logic             Clr;
   logic [N_REQ-1:0] Req;
   logic [N_REQ-1:0] Grant;
   logic             Ack;
   logic [WIDTH-1:0] GrayOut;
   logic             Overflow;
   logic             Busy;

   always #5 Clk = ~Clk;

   gray_count_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Req      (Req),
      .Clr      (Clr),
      .Grant    (Grant),
      .Ack      (Ack),
      .GrayOut  (GrayOut),
      .Overflow (Overflow),
      .Busy     (Busy)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: step count, sticky flag, last winner, cycles left in transaction.
   int               m_cnt;
   int               m_ptr;
   int               m_left;
   bit               m_ovf;
   bit               m_ack;
   logic [N_REQ-1:0] m_grant;

   function automatic int pick(input logic [N_REQ-1:0] r, input int ptr);
      int idx;
`ifdef GRAY_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N_REQ; i++) begin
         if (r[i]) return i;
      end
      idx = ptr;
`else
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (ptr + k) % N_REQ;
         if (r[idx]) return idx;
      end
`endif
      return -1;
   endfunction

   task automatic model_edge(input logic rst, input logic clr, input logic [N_REQ-1:0] req);
      int w;
      if (rst) begin
         m_cnt = 0; m_ovf = 0; m_ptr = N_REQ - 1; m_left = 0; m_grant = '0; m_ack = 0;
      end else if (clr) begin
         m_cnt = 0; m_ovf = 0; m_left = 0; m_grant = '0; m_ack = 0;
      end else if (m_left == 0) begin
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_ptr   = w;
            m_grant = N_REQ'(1 << w);
            m_left  = 2;
         end
      end else if (m_left == 2) begin
         m_cnt = (m_cnt + 1) % (1 << WIDTH);
         if (m_cnt == 0) m_ovf = 1;
         m_ack  = 1;
         m_left = 1;
      end else begin
         m_grant = '0; m_ack = 0; m_left = 0;
      end
   endtask

   task automatic check(input string nm, input int idx, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic cycle(input logic rst, input logic clr, input logic [N_REQ-1:0] req);
      Reset = rst;
      Clr   = clr;
      Req   = req;
      @(posedge Clk);
      model_edge(rst, clr, req);
      #1;
   endtask

   // One complete transaction with the request held throughout.
   task automatic txn(input logic [N_REQ-1:0] req, input int win, input int gray,
                      input int ovf, input int tag);
      cycle(1'b0, 1'b0, req);
      check("txn_grant", tag, int'(Grant), 1 << win);
      check("txn_noack", tag, int'(Ack), 0);
      cycle(1'b0, 1'b0, req);
      check("txn_ack", tag, int'(Ack), 1);
      check("txn_ackgrant", tag, int'(Grant), 1 << win);
      check("txn_gray", tag, int'(GrayOut), gray);
      check("txn_ovf", tag, int'(Overflow), ovf);
      cycle(1'b0, 1'b0, req);
      check("txn_release", tag, int'(Grant), 0);
      check("txn_ackdrop", tag, int'(Ack), 0);
      check("txn_idle", tag, int'(Busy), 0);
   endtask

   typedef struct {
      logic             rst;
      logic             clr;
      logic [N_REQ-1:0] req;
      logic [N_REQ-1:0] grant;
      logic             ack;
      logic [WIDTH-1:0] gray;
      logic             ovf;
      logic             busy;
   } vec_t;

   vec_t tbl[14];
   int   gray_tab[8];
   int   rr_gray[4];

   initial begin
      Reset = 1'b1;
      Clr   = 1'b0;
      Req   = '0;
      gray_tab = '{0, 1, 3, 2, 6, 7, 5, 4};
      rr_gray  = '{1, 3, 2, 6};

      tbl[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b0, 3'b000, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 3'b001, 1'b0, 1'b1};
      tbl[3]  = '{1'b0, 1'b0, 4'b0001, 4'b0000, 1'b0, 3'b001, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'b001, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 3'b001, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 4'b0010, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b0, 3'b000, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 4'b0000, 4'b0100, 1'b1, 3'b001, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0, 3'b000, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 3'b001, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'b001, 1'b0, 1'b0};

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].rst, tbl[i].clr, tbl[i].req);
         check("vec_grant", i, int'(Grant), int'(tbl[i].grant));
         check("vec_ack", i, int'(Ack), int'(tbl[i].ack));
         check("vec_gray", i, int'(GrayOut), int'(tbl[i].gray));
         check("vec_ovf", i, int'(Overflow), int'(tbl[i].ovf));
         check("vec_busy", i, int'(Busy), int'(tbl[i].busy));
      end

      // Arbitration order with all contenders held.
      cycle(1'b1, 1'b0, '0);
`ifdef GRAY_ARB_FIXED_PRIO_EN
      for (int t = 0; t < 4; t++) txn(4'b1010, 1, rr_gray[t], 0, t);
`else
      for (int t = 0; t < 4; t++) txn(4'b1111, t, rr_gray[t], 0, t);
`endif

      // Wrap and sticky overflow.
      cycle(1'b1, 1'b0, '0);
      for (int k = 1; k <= 9; k++) begin
         txn(4'b0001, 0, gray_tab[k % 8], (k >= 8) ? 1 : 0, 100 + k);
      end

      // Randomized traffic against the model.
      cycle(1'b1, 1'b0, '0);
      for (int n = 0; n < 2000; n++) begin
         logic             rr;
         logic             cc;
         logic [N_REQ-1:0] qq;
         rr = ($urandom_range(0, 149) == 0);
         cc = ($urandom_range(0, 59) == 0);
         qq = ($urandom_range(0, 3) == 0) ? '0 : N_REQ'($urandom_range(0, 15));
         cycle(rr, cc, qq);
         check("rnd_grant", n, int'(Grant), int'(m_grant));
         check("rnd_ack", n, int'(Ack), int'(m_ack));
         check("rnd_gray", n, int'(GrayOut), m_cnt ^ (m_cnt >> 1));
         check("rnd_ovf", n, int'(Overflow), int'(m_ovf));
         check("rnd_busy", n, int'(Busy), (m_left != 0) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gray_count_arbiter.md
Name: gray_count_arbiter

Overview:
- Shares one WIDTH-bit Gray-code step counter among N_REQ requesters.
- Round-robin arbitration: each granted request advances the shared count by exactly one step.
- Returns the new Gray value, and raises an overflow flag, on a one-cycle Ack to the winner.
- Sits between the control units that need monotonically advancing Gray tags and the single counter resource.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 3, counter width in bits; Gray value range 0..2^WIDTH-1

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
Req  input  N_REQ  per-requester step request, level; held until Ack
Clr  input  1  synchronous clear of count, overflow and FSM; lower priority than Reset
Grant  output  N_REQ  registered one-hot grant; all zero when no owner
Ack  output  1  one-cycle pulse; GrayOut/Overflow valid for the granted requester
GrayOut  output  WIDTH  Gray code of internal binary count: bin ^ (bin >> 1)
Overflow  output  1  sticky; set when count wraps from all-ones to 0
Busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock Clk.
- Reset values: Grant=0, Ack=0, GrayOut=0, Overflow=0, Busy=0, binary count=0, state=IDLE, rr pointer=N_REQ-1 so requester 0 wins first.
- FSM states: IDLE, GRANT, ACK. A transaction takes exactly 3 cycles; the next grant can occur 3 cycles after the previous one.
- IDLE:
  - If Req != 0 at the edge: latch the one-hot winner into Grant, set rr pointer = winner index, go to GRANT.
  - Otherwise stay in IDLE.
- Round-robin search: start at pointer+1 mod N_REQ and take the first set Req bit.
- GRANT (Grant held):
  - At the edge, bin <= bin+1 mod 2^WIDTH.
  - If bin was all-ones: bin wraps to 0 and Overflow <= 1.
  - Go to ACK.
  - The step is committed even if the winner deasserted Req during GRANT.
- ACK:
  - Ack=1, Grant still held, GrayOut shows the updated value.
  - At the edge: Grant <= 0, Ack <= 0, go to IDLE.
  - Req of the winner must drop in the Ack cycle. If still high, it re-competes in IDLE at lowest round-robin priority.
- GrayOut is registered from the updated bin, so it changes on the same edge as the count.
- Overflow is sticky. It is cleared only by Reset or Clr; further wraps leave it at 1.
- Clr (any state):
  - At the edge: bin=0, GrayOut=0, Overflow=0, Grant=0, Ack=0, state=IDLE.
  - The rr pointer is kept.
  - An in-flight step is aborted and never Acked.
- Reset overrides Clr. Reset mid-transaction gives the full reset values on the next edge.
- Req changes during GRANT/ACK are ignored; arbitration happens only in IDLE.
- Grant is always one-hot or zero. Ack=1 implies exactly one Grant bit set.

Optional Feature:
GRAY_ARB_FIXED_PRIO_EN
- Defined: arbitration is fixed priority, lowest index set in Req wins; rr pointer is removed.
- Undefined: round-robin as specified above.
- All other timing and outputs are identical in both builds.

Test Plan:
- Reset, then Req=4'b0001 held → Grant=0001 on edge 1, Ack=1 on edge 2 with GrayOut=3'b001; Grant=0 and Ack=0 on edge 3.
- Req=4'b1111 held for 12 cycles → grant order 0,1,2,3; GrayOut at each Ack = 001, 011, 010, 110.
- 8 single steps from reset → 8th Ack shows GrayOut=000, Overflow=1; 9th step gives GrayOut=001 with Overflow still 1.
- Clr asserted in GRANT cycle → next edge: Ack never pulses, GrayOut=000, Overflow=0, Busy=0.
- Reset asserted in ACK with Clr also high → all outputs 0; next Req=0010 is granted to requester 1.
- With GRAY_ARB_FIXED_PRIO_EN, Req=4'b1010 held → requester 1 wins every transaction; requester 3 is never granted.
